imc_array_digital_model: RTL and testbench
==========================================

// Module: imc_array_digital_model
// PURPOSE
//  Cycle-accurate digital responder for the SRAM compute-in-memory array interface, i.e. the array end
//  of the controller's WWL/WE/Din write port and RWL/RWLB/PRE_*/EN/SAEN read-compute port.
//  Stores a ROWS x COLS weight array and returns SA_OUT (memory read) or per-column ADC codes (XNOR-popcount).
//  Replaces the analog array in FPGA prototypes and digital sims; also flags controller protocol violations.
// PARAMETERS
//  ROWS      16  word lines (WWL/RWL/RWLB width)
//  COLS      16  bit lines (Din/SA_OUT width, one ADC per column)
//  ADC_BITS  4   ADC code width per column; IMC_out width = COLS*ADC_BITS
//  EVAL_MIN  1   minimum cycles EN must be high before SAEN is legal
// PORTS
//  clk       in   1              common clock, rising edge
//  reset_n   in   1              asynchronous active-low reset
//  WWL       in   ROWS           write word lines, one bit per row
//  WE        in   1              write enable
//  Din       in   COLS           write data
//  PRE_SRAM  in   1              bit-line precharge
//  PRE_VLSA  in   1              voltage-latch SA precharge; selects READ mode
//  PRE_CLSA  in   1              current-latch SA precharge; selects CIM mode (with PRE_A)
//  PRE_A     in   1              ADC precharge
//  EN        in   1              evaluate enable
//  RWL       in   ROWS           read word lines (true input)
//  RWLB      in   ROWS           read word lines (complement input)
//  SAEN      in   1              sense/ADC strobe
//  SA_OUT    out  COLS           read data
//  IMC_out   out  COLS*ADC_BITS  ADC codes; column c at [c*ADC_BITS +: ADC_BITS]
//  res_valid out  1              1-cycle pulse: SA_OUT/IMC_out updated
//  proto_err out  1              1-cycle pulse: protocol violation detected
// BEHAVIOUR
//  Reset: array, SA_OUT, IMC_out = 0; res_valid = proto_err = 0; FSM = IDLE.
//  Write (IDLE only): WE=1 at edge -> every row r with WWL[r]=1 gets Din (multi-hot broadcasts).
//   WWL=0 is a no-op. WE=1 in any non-IDLE state -> write dropped and proto_err.
//  FSM IDLE -> PRECH: on PRE_SRAM=1. Mode latched at this edge:
//   READ if PRE_VLSA & !PRE_CLSA; CIM if PRE_CLSA & PRE_A & !PRE_VLSA; otherwise proto_err, stay IDLE.
//  PRECH: hold while PRE_SRAM=1. PRE_SRAM=0 & EN=1 -> EVAL; latch RWL/RWLB; eval_cnt=1.
//   PRE_SRAM=0 & EN=0 -> IDLE (abort, no error).
//  EVAL: eval_cnt increments (saturating). EN=0, or RWL/RWLB differing from latched value -> proto_err, IDLE.
//   SAEN=1 with eval_cnt>=EVAL_MIN -> SENSE; with eval_cnt<EVAL_MIN -> proto_err, IDLE.
//  SENSE: results registered at the SENSE-entry edge; res_valid high for exactly that next cycle.
//   Stay in SENSE until SAEN=0 & EN=0, then IDLE. Outputs hold until the next SENSE.
//  READ result: latched RWL must be one-hot and RWLB=0; SA_OUT = row[onehot]; IMC_out unchanged.
//   Zero-hot/multi-hot RWL or RWLB!=0 -> proto_err, no res_valid, SA_OUT unchanged, FSM -> IDLE.
//  CIM result per column c: cnt = sum_r (RWL[r] & w[r][c]) + (RWLB[r] & !w[r][c]).
//   cnt range 0..ROWS; code = min(cnt, 2^ADC_BITS-1) (saturate 16 -> 15). SA_OUT unchanged.
//   Any r with RWL[r]=RWLB[r]=1 -> proto_err, no res_valid, IMC_out unchanged, FSM -> IDLE.
//  Latency: SAEN sampled at edge N -> outputs valid, res_valid=1 in cycle N+1.
//  Simultaneous: errors take priority over transitions; proto_err never coincides with res_valid.
//  Reset mid-operation: immediate return to reset values; array contents are cleared as well.
// TESTING
//  T1 write: WE=1,WWL=0x0004,Din=0xA5C3; READ seq RWL=0x0004 -> SA_OUT=0xA5C3, res_valid 1 cycle after SAEN.
//  T2 CIM: all rows=0xFFFF, RWL=0xFFFF,RWLB=0 -> every code saturates to 15; RWL=0x00FF -> every code 8.
//  T3 XNOR: row0=0x0001 only, RWL=0, RWLB=0x0001 -> col0 code 0, cols1..15 code 1.
//  T4 protocol: SAEN in PRECH, EN drop in EVAL, RWL change in EVAL, WE in EVAL -> proto_err each, no res_valid, array unchanged.
//  T5 READ with RWL=0x0003 -> proto_err, SA_OUT holds previous 0xA5C3; PRE_VLSA&PRE_CLSA at entry -> proto_err, stays IDLE.
//  T6 reset_n low during EVAL -> all outputs 0 asynchronously, FSM IDLE; next READ of row 2 returns 0x0000.

Source files
------------

// File: rtl/imc_array_digital_model.sv
// Cycle-accurate digital stand-in for the SRAM compute-in-memory array.
// Holds a ROWS x COLS weight array and answers the controller's write, read
// and XNOR-popcount compute sequences. Illegal controller sequences are
// reported on proto_err.
module imc_array_digital_model #(
    parameter int unsigned ROWS     = 16,
    parameter int unsigned COLS     = 16,
    parameter int unsigned ADC_BITS = 4,
    parameter int unsigned EVAL_MIN = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ROWS-1:0]          WWL,
    input  logic                     WE,
    input  logic [COLS-1:0]          Din,
    input  logic                     PRE_SRAM,
    input  logic                     PRE_VLSA,
    input  logic                     PRE_CLSA,
    input  logic                     PRE_A,
    input  logic                     EN,
    input  logic [ROWS-1:0]          RWL,
    input  logic [ROWS-1:0]          RWLB,
    input  logic                     SAEN,
    output logic [COLS-1:0]          SA_OUT,
    output logic [COLS*ADC_BITS-1:0] IMC_out,
    output logic                     res_valid,
    output logic                     proto_err
);

    // Eval counter only needs to reach EVAL_MIN; it saturates at all-ones.
    localparam int unsigned EcW = $clog2(EVAL_MIN + 2);
    localparam logic [EcW-1:0] EvalMin = EcW'(EVAL_MIN);
    localparam logic [EcW-1:0] EcOne = EcW'(1);
    localparam int unsigned CodeMax = (1 << ADC_BITS) - 1;

    typedef enum logic [1:0] {
        StIdle,
        StPrech,
        StEval,
        StSense
    } state_e;

    state_e state_q, state_d;

    logic [COLS-1:0]          mem_q [ROWS];
    logic                     cim_q, cim_d;
    logic [ROWS-1:0]          rwl_q, rwl_d;
    logic [ROWS-1:0]          rwlb_q, rwlb_d;
    logic [EcW-1:0]           ec_q, ec_d;
    logic [COLS-1:0]          sa_q;
    logic [COLS*ADC_BITS-1:0] imc_q;
    logic                     res_valid_q;
    logic                     proto_err_q;

    logic                     err;
    logic                     go_sense;
    logic                     wr_en;
    logic                     read_sel;
    logic                     cim_sel;
    logic                     read_ok;
    logic                     cim_conflict;
    logic [COLS-1:0]          rd_data;
    logic [COLS*ADC_BITS-1:0] cim_codes;
    int unsigned              cnt_v;

    assign SA_OUT    = sa_q;
    assign IMC_out   = imc_q;
    assign res_valid = res_valid_q;
    assign proto_err = proto_err_q;

    // Mode decode from the precharge pattern seen at PRECH entry.
    assign read_sel = PRE_VLSA && !PRE_CLSA;
    assign cim_sel  = PRE_CLSA && PRE_A && !PRE_VLSA;

    // Memory read path: latched RWL must select exactly one row.
    always_comb begin
        rd_data = '0;
        read_ok = $onehot(rwl_q) && (rwlb_q == '0);
        for (int r = 0; r < ROWS; r++) begin
            if (rwl_q[r]) begin
                rd_data = mem_q[r];
            end
        end
    end

    // XNOR-popcount per column, saturated to the ADC code range.
    always_comb begin
        cim_codes    = '0;
        cnt_v        = 0;
        cim_conflict = |(rwl_q & rwlb_q);
        for (int c = 0; c < COLS; c++) begin
            cnt_v = 0;
            for (int r = 0; r < ROWS; r++) begin
                if ((rwl_q[r] && mem_q[r][c]) || (rwlb_q[r] && !mem_q[r][c])) begin
                    cnt_v = cnt_v + 32'd1;
                end
            end
            cim_codes[c*ADC_BITS +: ADC_BITS] =
                (cnt_v > CodeMax) ? ADC_BITS'(CodeMax) : ADC_BITS'(cnt_v);
        end
    end

    // Protocol FSM next state; any error forces IDLE and blocks the transition.
    always_comb begin
        state_d  = state_q;
        cim_d    = cim_q;
        rwl_d    = rwl_q;
        rwlb_d   = rwlb_q;
        ec_d     = ec_q;
        err      = 1'b0;
        go_sense = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                wr_en = WE;
                if (PRE_SRAM) begin
                    if (read_sel) begin
                        state_d = StPrech;
                        cim_d   = 1'b0;
                    end else if (cim_sel) begin
                        state_d = StPrech;
                        cim_d   = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            StPrech: begin
                if (WE || SAEN) begin
                    err = 1'b1;
                end else if (!PRE_SRAM) begin
                    if (EN) begin
                        state_d = StEval;
                        rwl_d   = RWL;
                        rwlb_d  = RWLB;
                        ec_d    = EcOne;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StEval: begin
                ec_d = (ec_q == '1) ? ec_q : ec_q + EcOne;
                if (WE || !EN || (RWL != rwl_q) || (RWLB != rwlb_q)) begin
                    err = 1'b1;
                end else if (SAEN) begin
                    if (ec_q < EvalMin) begin
                        err = 1'b1;
                    end else if (!cim_q && !read_ok) begin
                        err = 1'b1;
                    end else if (cim_q && cim_conflict) begin
                        err = 1'b1;
                    end else begin
                        go_sense = 1'b1;
                        state_d  = StSense;
                    end
                end
            end
            StSense: begin
                if (WE) begin
                    err = 1'b1;
                end else if (!SAEN && !EN) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (err) begin
            state_d = StIdle;
        end
    end

    // State, array and result registers; reset also clears the array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cim_q       <= 1'b0;
            rwl_q       <= '0;
            rwlb_q      <= '0;
            ec_q        <= '0;
            sa_q        <= '0;
            imc_q       <= '0;
            res_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cim_q       <= cim_d;
            rwl_q       <= rwl_d;
            rwlb_q      <= rwlb_d;
            ec_q        <= ec_d;
            res_valid_q <= go_sense;
            proto_err_q <= err;
            if (go_sense) begin
                if (cim_q) begin
                    imc_q <= cim_codes;
                end else begin
                    sa_q <= rd_data;
                end
            end
            if (wr_en) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (WWL[r]) begin
                        mem_q[r] <= Din;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imc_array_digital_model.sv
// Scoreboard bench for imc_array_digital_model: stimulus pushes the expected
// response (result or protocol error, with held outputs and arrival cycle),
// a negedge monitor pops and compares whenever res_valid or proto_err fires.
module tb_imc_array_digital_model;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] WWL, Din, RWL, RWLB;
    logic        WE, PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, EN, SAEN;
    logic [15:0] SA_OUT;
    logic [63:0] IMC_out;
    logic        res_valid, proto_err;

    typedef struct {
        bit          is_err;
        logic [15:0] sa;
        logic [63:0] imc;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_sa = '0;
    logic [63:0] exp_imc = '0;

    imc_array_digital_model dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .WWL       (WWL),
        .WE        (WE),
        .Din       (Din),
        .PRE_SRAM  (PRE_SRAM),
        .PRE_VLSA  (PRE_VLSA),
        .PRE_CLSA  (PRE_CLSA),
        .PRE_A     (PRE_A),
        .EN        (EN),
        .RWL       (RWL),
        .RWLB      (RWLB),
        .SAEN      (SAEN),
        .SA_OUT    (SA_OUT),
        .IMC_out   (IMC_out),
        .res_valid (res_valid),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && (res_valid || proto_err)) begin
            chk("valid_err_exclusive", 64'(res_valid && proto_err), 64'd0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=valid%0d/err%0d required=none",
                         res_valid, proto_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_kind", 64'(proto_err), 64'(e.is_err));
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                chk("sa_out", 64'(SA_OUT), 64'(e.sa));
                chk("imc_out", IMC_out, e.imc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        WWL = '0; Din = '0; RWL = '0; RWLB = '0;
        WE = 0; PRE_SRAM = 0; PRE_VLSA = 0; PRE_CLSA = 0; PRE_A = 0; EN = 0; SAEN = 0;
    endtask

    // Event is expected right after the next clock edge.
    task automatic push(input bit is_err);
        exp_t e;
        e.is_err = is_err;
        e.sa     = exp_sa;
        e.imc    = exp_imc;
        e.cyc    = cyc + 1;
        q.push_back(e);
    endtask

    task automatic write_row(input logic [15:0] wwl, input logic [15:0] din);
        WE = 1; WWL = wwl; Din = din;
        tick();
        WE = 0; WWL = '0; Din = '0;
    endtask

    task automatic enter_eval(input bit cim, input logic [15:0] rwl, input logic [15:0] rwlb);
        PRE_SRAM = 1;
        if (cim) begin
            PRE_CLSA = 1; PRE_A = 1;
        end else begin
            PRE_VLSA = 1;
        end
        tick();
        PRE_SRAM = 0; PRE_VLSA = 0; PRE_CLSA = 0; PRE_A = 0;
        EN = 1; RWL = rwl; RWLB = rwlb;
        tick();
    endtask

    task automatic sense(input bit is_err);
        push(is_err);
        SAEN = 1;
        tick();
        SAEN = 0; EN = 0;
        tick();
        idle_inputs();
        tick();
    endtask

    // Error already set up on the inputs; clock it and return to idle.
    task automatic clock_err();
        push(1'b1);
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic do_read(input logic [15:0] rwl, input logic [15:0] sa);
        enter_eval(1'b0, rwl, 16'h0000);
        exp_sa = sa;
        sense(1'b0);
    endtask

    task automatic do_cim(input logic [15:0] rwl, input logic [15:0] rwlb,
                          input logic [63:0] imc);
        enter_eval(1'b1, rwl, rwlb);
        exp_imc = imc;
        sense(1'b0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        repeat (2) tick();
        chk("reset_sa_out", 64'(SA_OUT), 64'd0);
        chk("reset_imc_out", IMC_out, 64'd0);
        chk("reset_flags", {62'd0, res_valid, proto_err}, 64'd0);
        @(negedge clk);
        reset_n = 1;
        tick();

        // T1: write row 2, read it back.
        write_row(16'h0004, 16'hA5C3);
        do_read(16'h0004, 16'hA5C3);

        // T2: broadcast all-ones; full popcount saturates, half gives 8.
        write_row(16'hFFFF, 16'hFFFF);
        do_cim(16'hFFFF, 16'h0000, {16{4'hF}});
        do_cim(16'h00FF, 16'h0000, {16{4'h8}});

        // T5: multi-hot read errors and holds SA_OUT; bad mode stays IDLE.
        enter_eval(1'b0, 16'h0003, 16'h0000);
        sense(1'b1);
        chk("t5_sa_hold", 64'(SA_OUT), 64'hA5C3);
        PRE_SRAM = 1; PRE_VLSA = 1; PRE_CLSA = 1;
        clock_err();
        write_row(16'h0008, 16'h1234);
        do_read(16'h0008, 16'h1234);

        // T3: XNOR through RWLB.
        write_row(16'hFFFF, 16'h0000);
        write_row(16'h0001, 16'h0001);
        do_cim(16'h0000, 16'h0001, 64'h1111_1111_1111_1110);
        do_read(16'h0001, 16'h0001);

        // T4: protocol violations.
        PRE_SRAM = 1; PRE_VLSA = 1;
        tick();
        SAEN = 1;
        clock_err();
        enter_eval(1'b0, 16'h0004, 16'h0000);
        EN = 0;
        clock_err();
        enter_eval(1'b0, 16'h0004, 16'h0000);
        RWL = 16'h0008;
        clock_err();
        enter_eval(1'b0, 16'h0001, 16'h0000);
        WE = 1; WWL = 16'h0001; Din = 16'hFFFF;
        clock_err();
        enter_eval(1'b1, 16'h0001, 16'h0001);
        sense(1'b1);
        do_read(16'h0001, 16'h0001);

        // T6: asynchronous reset mid-EVAL clears outputs and array.
        write_row(16'h0004, 16'hA5C3);
        do_read(16'h0004, 16'hA5C3);
        enter_eval(1'b0, 16'h0004, 16'h0000);
        #2;
        reset_n = 0;
        #1;
        chk("t6_async_sa_out", 64'(SA_OUT), 64'd0);
        chk("t6_async_imc_out", IMC_out, 64'd0);
        chk("t6_async_flags", {62'd0, res_valid, proto_err}, 64'd0);
        exp_sa  = '0;
        exp_imc = '0;
        idle_inputs();
        @(negedge clk);
        reset_n = 1;
        tick();
        do_read(16'h0004, 16'h0000);
        do_cim(16'h0000, 16'hFFFF, {16{4'hF}});

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
